// File: rtl/sgpio_pkg.sv
// Shared constants and FSM encoding for the SGPIO master.
package sgpio_pkg;
  localparam int SGPIO_FRAME_BITS  = 8;
  localparam int SGPIO_CLK_DIV_MIN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLOSE = 2'd2
  } sgpio_state_e;
endpackage

// File: rtl/sgpio_if.sv
// 4-wire SGPIO cable: master drives clk/sync/mosi, slave drives miso.
interface sgpio_if;
  logic sgpio_clk;
  logic sgpio_sync;
  logic sgpio_mosi;
  logic sgpio_miso;

  modport master (output sgpio_clk, sgpio_sync, sgpio_mosi, input sgpio_miso);
  modport slave  (input sgpio_clk, sgpio_sync, sgpio_mosi, output sgpio_miso);
endinterface

// File: rtl/sgpio_sync2.sv
// Two-flop synchroniser for the asynchronous MISO line; resets to 0.
module sgpio_sync2 (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/sgpio_master.sv
// SGPIO master: divided serial clock, sync-marked 8-bit TX frame, MISO deserialiser.
// Build option SGPIO_LED_FILTER_EN: only publish an LED byte seen in two consecutive frames.
module sgpio_master
  import sgpio_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_enable,
  input  logic [SGPIO_FRAME_BITS-1:0] i_user_sw,
  output logic [SGPIO_FRAME_BITS-1:0] o_user_led,
  output logic                        o_user_led_valid,
  output logic                        o_frame_done,
  sgpio_if.master                     link
);
  // Divisors below the minimum leave no room for the MISO synchroniser latency.
  localparam int CDIV = (CLK_DIV < SGPIO_CLK_DIV_MIN) ? SGPIO_CLK_DIV_MIN : CLK_DIV;
  localparam int DW   = $clog2(2 * CDIV);
  localparam int BW   = $clog2(SGPIO_FRAME_BITS);
  localparam logic [DW-1:0] DIV_RISE = DW'(CDIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CDIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CDIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SGPIO_FRAME_BITS - 1);

  sgpio_state_e state, state_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt;
  logic [SGPIO_FRAME_BITS-1:0] sw_q;
  logic [SGPIO_FRAME_BITS-2:0] rx_sr;
  logic [SGPIO_FRAME_BITS-1:0] cap;
  logic sclk_q, sync_q, mosi_q;
  logic full;
  logic miso_s;
  logic rise, period_end, frame_start, capture;
`ifdef SGPIO_LED_FILTER_EN
  logic [SGPIO_FRAME_BITS-1:0] prev_cap;
  logic                        prev_vld;
`endif

  sgpio_sync2 u_miso_sync (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .d     (link.sgpio_miso),
    .q     (miso_s)
  );

  assign link.sgpio_clk  = sclk_q;
  assign link.sgpio_sync = sync_q;
  assign link.sgpio_mosi = mosi_q;

  assign cap     = {miso_s, rx_sr};
  assign capture = rise && (bit_cnt == '0) && full;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rise        = 1'b0;
    period_end  = 1'b0;
    frame_start = 1'b0;
    div_nxt     = '0;
    if (state != IDLE) begin
      rise       = (div_cnt == DIV_RISE);
      period_end = (div_cnt == DIV_LAST);
    end
    unique case (state)
      IDLE:  if (i_enable) begin
               state_nxt   = RUN;
               frame_start = 1'b1;
             end
      // Enable is only looked at on the b=7 -> b=0 boundary.
      RUN:   if (period_end && bit_cnt == LAST_BIT) begin
               frame_start = 1'b1;
               if (!i_enable) state_nxt = CLOSE;
             end
      CLOSE: if (period_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && state_nxt != IDLE && !period_end)
      div_nxt = div_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      div_cnt          <= '0;
      bit_cnt          <= '0;
      sw_q             <= '0;
      rx_sr            <= '0;
      sclk_q           <= 1'b0;
      sync_q           <= 1'b0;
      mosi_q           <= 1'b0;
      full             <= 1'b0;
      o_user_led       <= '0;
      o_user_led_valid <= 1'b0;
      o_frame_done     <= 1'b0;
`ifdef SGPIO_LED_FILTER_EN
      prev_cap         <= '0;
      prev_vld         <= 1'b0;
`endif
    end else begin
      div_cnt      <= div_nxt;
      sclk_q       <= (state_nxt != IDLE) && (div_nxt >= DIV_HALF);
      o_frame_done <= 1'b0;

      // The CLOSE period reuses the frame-start marking (sync=1, fresh sw bit 0).
      if (frame_start) begin
        sw_q    <= i_user_sw;
        sync_q  <= 1'b1;
        mosi_q  <= i_user_sw[0];
        bit_cnt <= '0;
      end else if (state_nxt == IDLE) begin
        sync_q  <= 1'b0;
        mosi_q  <= 1'b0;
        bit_cnt <= '0;
      end else if (period_end) begin
        bit_cnt <= bit_cnt + 1'b1;
        sync_q  <= 1'b0;
        mosi_q  <= sw_q[bit_cnt + 1'b1];
      end

      // A b=0 capture is only trusted once a whole frame has run since RUN entry.
      if (state == IDLE)    full <= 1'b0;
      else if (frame_start) full <= 1'b1;

      if (rise && bit_cnt != '0) rx_sr[bit_cnt - 1'b1] <= miso_s;

`ifdef SGPIO_LED_FILTER_EN
      if (state == IDLE) prev_vld <= 1'b0;
      if (capture) begin
        prev_cap <= cap;
        prev_vld <= 1'b1;
        if (prev_vld && prev_cap == cap) begin
          o_user_led       <= cap;
          o_user_led_valid <= 1'b1;
          o_frame_done     <= 1'b1;
        end
      end
`else
      if (capture) begin
        o_user_led       <= cap;
        o_user_led_valid <= 1'b1;
        o_frame_done     <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_sgpio_master.sv
// Loopback bench: behavioural SGPIO slave on the cable plus a frame-timing reference model.
module tb_sgpio_master;
  localparam int CD   = 8;
  localparam int P    = 2 * CD;
  localparam int F    = 8 * P;
  localparam int MAXF = 16;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_enable = 1'b0;
  logic [7:0] i_user_sw = '0;
  logic [7:0] o_user_led;
  logic       o_user_led_valid;
  logic       o_frame_done;

  sgpio_if link ();

  sgpio_master #(.CLK_DIV(CD)) dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .i_enable        (i_enable),
    .i_user_sw       (i_user_sw),
    .o_user_led      (o_user_led),
    .o_user_led_valid(o_user_led_valid),
    .o_frame_done    (o_frame_done),
    .link            (link)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc = cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Remote slave: snapshots its LED byte at sync, returns it LSB first, decodes MOSI frames.
  logic [7:0] slave_led = 8'h3C;
  logic [7:0] s_snap = '0;
  logic [7:0] s_rx = '0;
  logic       s_miso = 1'b0;
  int         s_pos = 0;
  int         s_cnt = 0;
  logic [7:0] s_rxq[$];
  assign link.sgpio_miso = s_miso;

  always @(posedge link.sgpio_clk) begin
    if (link.sgpio_sync) begin
      if (s_cnt == 8) s_rxq.push_back(s_rx);
      s_cnt  = 0;
      s_pos  = 0;
      s_snap = slave_led;
    end else s_pos = s_pos + 1;
    if (s_cnt < 8) s_rx[s_cnt[2:0]] = link.sgpio_mosi;
    s_cnt = s_cnt + 1;
  end

  always @(negedge link.sgpio_clk) s_miso = s_snap[s_pos[2:0]];

  // Reference model: one run = n frames from entry cycle run_e, then one CLOSE period.
  bit         chk_on = 1'b0;
  bit         run_on = 1'b0;
  int         run_e = 0;
  int         run_n = 0;
  logic [7:0] fsw [0:MAXF];
  logic [7:0] snap[0:MAXF];
  logic [7:0] exp_led = '0;
  logic       exp_vld = 1'b0;

  function automatic bit upd(input int k);
`ifdef SGPIO_LED_FILTER_EN
    return (k >= 1) && (snap[k] == snap[k-1]);
`else
    return 1'b1;
`endif
  endfunction

  always @(negedge i_clk) begin
    int t, p, ph, k, b;
    logic ec, es, em, ed;
    if (!i_rstn) begin
      exp_vld = 1'b0;
      exp_led = '0;
    end else if (chk_on) begin
      ec = 1'b0; es = 1'b0; em = 1'b0; ed = 1'b0;
      t = cyc - run_e;
      if (run_on && t >= 0 && t < run_n * F + P) begin
        p  = t / P;
        ph = t % P;
        ec = (ph >= CD);
        if (p < 8 * run_n) begin
          b  = p % 8;
          k  = p / 8;
          es = (b == 0);
          em = fsw[k][b];
        end else begin
          es = 1'b1;
          em = fsw[run_n][0];
        end
        if (t >= F + CD && (t - CD) % F == 0) begin
          k = (t - CD) / F - 1;
          if (k < run_n && upd(k)) begin
            ed      = 1'b1;
            exp_led = snap[k];
            exp_vld = 1'b1;
          end
        end
      end
      chk("link", {link.sgpio_clk, link.sgpio_sync, link.sgpio_mosi, o_frame_done,
                   o_user_led_valid, o_user_led}, {ec, es, em, ed, exp_vld, exp_led});
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge i_clk);
  endtask

  function automatic logic [7:0] nled(input int mode, input int k, input logic [7:0] cur);
    if (mode == 1) return 8'h3C;
    if (mode == 2) return (k + 1 == 2) ? 8'hFF : 8'h3C;
    return ($urandom_range(0, 1) != 0) ? cur : 8'($urandom);
  endfunction

  // mode 0: random sw/led; 1: A5->5A with led 3C; 2: led 3C,3C,FF,3C,3C.
  task automatic run(input int n, input int abort_k, input int mode);
    int e, base;
    base = s_rxq.size();
    if (mode != 0) slave_led = 8'h3C;
    fsw[0]  = i_user_sw;
    snap[0] = slave_led;
    run_n   = n;
    run_e   = cyc + 1;
    run_on  = 1'b1;
    e       = run_e;
    i_enable = 1'b1;
    for (int k = 0; k < n; k++) begin
      int f0;
      f0 = e + k * F;
      if (k == n - 1) begin
        wait_cyc(f0 + 3 * P + 2);
        i_enable = 1'b0;
      end
      wait_cyc(f0 + F / 2);
      i_user_sw = (mode == 1) ? 8'h5A : 8'($urandom);
      slave_led = nled(mode, k, slave_led);
      if (k == abort_k) begin
        wait_cyc(f0 + 5 * P + 3);
        i_rstn   = 1'b0;
        run_on   = 1'b0;
        i_enable = 1'b0;
        #1;
        chk("rst_mid", {link.sgpio_clk, link.sgpio_sync, link.sgpio_mosi, o_frame_done,
                        o_user_led_valid, o_user_led}, 32'h0);
        repeat (4) @(negedge i_clk);
        i_rstn = 1'b1;
        repeat (10) @(negedge i_clk);
        return;
      end
      if (k != n - 1 && k % 2 == 1) begin
        wait_cyc(f0 + 5 * P);
        i_enable = 1'b0;
        wait_cyc(f0 + 6 * P);
        i_enable = 1'b1;
      end
      wait_cyc(f0 + F - 1);
      fsw[k+1]  = i_user_sw;
      snap[k+1] = slave_led;
    end
    wait_cyc(e + n * F + P + 20);
    chk("slv_nfrm", s_rxq.size() - base, n);
    for (int k = 0; k < n; k++)
      if (base + k < s_rxq.size()) chk("slv_frm", s_rxq[base+k], fsw[k]);
    if (mode == 1 && s_rxq.size() >= base + 2) begin
      chk("dir_sw0", s_rxq[base], 8'hA5);
      chk("dir_sw1", s_rxq[base+1], 8'h5A);
      chk("dir_led", o_user_led, 8'h3C);
      chk("dir_vld", o_user_led_valid, 1'b1);
    end
    if (mode == 2) chk("glt_led", o_user_led, 8'h3C);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_clk",  link.sgpio_clk,   1'b0);
    chk("rst_sync", link.sgpio_sync,  1'b0);
    chk("rst_mosi", link.sgpio_mosi,  1'b0);
    chk("rst_led",  o_user_led,       8'h00);
    chk("rst_vld",  o_user_led_valid, 1'b0);
    chk("rst_done", o_frame_done,     1'b0);
    i_rstn = 1'b1;
    chk_on = 1'b1;
    repeat (30) @(negedge i_clk);
    chk("idle_clk", link.sgpio_clk, 1'b0);

    i_user_sw = 8'hA5;
    run(3, -1, 1);
    run(5, -1, 0);
    run(6, 2, 0);
    run(4, -1, 0);
    run(5, -1, 2);
    run(4, -1, 0);

    repeat (20) @(negedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
